// File: rtl/multicycle_control_fsm_if.sv
// Control-side bundle between the multi-cycle sequencer, the instruction register,
// the instruction/data memories and the datapath enables.
interface multicycle_control_fsm_if;
  // Inputs to the sequencer
  logic [6:0] Opcode;
  logic       imem_ack;
  logic       dmem_ack;
  // Memory requests
  logic       imem_req;
  logic       MemRead;
  logic       MemWrite;
  // Datapath enables and selects
  logic       IRWrite;
  logic       PCWrite;
  logic       ALUSrc;
  logic [1:0] ALUOp;
  logic       MemtoReg;
  logic       RegWrite;
  // Status
  logic       illegal_instr;
  logic       mem_fault;
  logic [2:0] state;

  // Sequencer side
  modport master (
    input  Opcode, imem_ack, dmem_ack,
    output imem_req, MemRead, MemWrite, IRWrite, PCWrite, ALUSrc, ALUOp,
           MemtoReg, RegWrite, illegal_instr, mem_fault, state
  );

  // Datapath / memory side
  modport slave (
    output Opcode, imem_ack, dmem_ack,
    input  imem_req, MemRead, MemWrite, IRWrite, PCWrite, ALUSrc, ALUOp,
           MemtoReg, RegWrite, illegal_instr, mem_fault, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I datapath (R-type, I-type ALU, load, store).
// Walks FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data memory, and aborts a
// memory request that waits TIMEOUT cycles without an ack.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_control_fsm_if.master bus
);

  // State encoding is visible on the state output, so it is fixed.
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_MEM = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [TO_WIDTH-1:0] WAIT_LAST = TO_WIDTH'(TIMEOUT - 1);

  logic [2:0]          state_q, state_d;
  logic [6:0]          op_q, op_d;
  logic [TO_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  // Instruction class of the latched opcode
  logic is_r, is_i, is_ld, is_st;
  // Legality of the opcode presented during DECODE
  logic opcode_legal;
  logic timeout_hit;

  // Raw (ungated) outputs
  logic       imem_req_raw;
  logic       mem_read_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       alu_src_raw;
  logic [1:0] alu_op_raw;
  logic       mem_to_reg_raw;
  logic       reg_write_raw;
  logic       illegal_raw;
  logic       fault_raw;

  // ALU controls that EXEC drives and WB holds
  logic       exe_alu_src;
  logic [1:0] exe_alu_op;

  assign is_r  = (op_q == OP_R);
  assign is_i  = (op_q == OP_I);
  assign is_ld = (op_q == OP_LD);
  assign is_st = (op_q == OP_ST);

  assign opcode_legal = (bus.Opcode == OP_R)  || (bus.Opcode == OP_I) ||
                        (bus.Opcode == OP_LD) || (bus.Opcode == OP_ST);

  assign timeout_hit = (wait_cnt_q == WAIT_LAST);

  // ALU source/operation selected by instruction class
  always_comb begin
    exe_alu_src = 1'b1;
    exe_alu_op  = ALUOP_MEM;
    if (is_r) begin
      exe_alu_src = 1'b0;
      exe_alu_op  = ALUOP_R;
    end else if (is_i) begin
      exe_alu_src = 1'b1;
      exe_alu_op  = ALUOP_ADD;
    end
  end

  // Next state, opcode latch, wait counter and the handshake-driven pulses
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_cnt_d   = '0;
    ir_write_raw = 1'b0;
    illegal_raw  = 1'b0;
    fault_raw    = 1'b0;
    case (state_q)
      FETCH: begin
        // An ack always beats a simultaneous timeout.
        if (bus.imem_ack) begin
          ir_write_raw = 1'b1;
          state_d      = DECODE;
        end else if (timeout_hit) begin
          // Abandon the fetch; re-entering FETCH refetches the same PC.
          fault_raw = 1'b1;
          state_d   = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_WIDTH'(1);
        end
      end
      DECODE: begin
        op_d = bus.Opcode;
        if (opcode_legal) begin
          state_d = EXEC;
        end else begin
          illegal_raw = 1'b1;
          state_d     = FETCH;
        end
      end
      EXEC: begin
        if (is_r || is_i) begin
          state_d = WB;
        end else if (is_ld || is_st) begin
          state_d = MEM;
        end else begin
          state_d = FETCH;
        end
      end
      MEM: begin
        if (bus.dmem_ack) begin
          state_d = is_ld ? WB : FETCH;
        end else if (timeout_hit) begin
          fault_raw = 1'b1;
          state_d   = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_WIDTH'(1);
        end
      end
      WB: begin
        state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Moore decode of state and latched opcode
  always_comb begin
    imem_req_raw   = 1'b0;
    mem_read_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    alu_src_raw    = 1'b0;
    alu_op_raw     = 2'b00;
    mem_to_reg_raw = 1'b0;
    reg_write_raw  = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req_raw = 1'b1;
      end
      EXEC: begin
        alu_src_raw = exe_alu_src;
        alu_op_raw  = exe_alu_op;
      end
      MEM: begin
        alu_src_raw   = 1'b1;
        alu_op_raw    = ALUOP_MEM;
        mem_read_raw  = is_ld;
        mem_write_raw = is_st;
      end
      WB: begin
        alu_src_raw    = exe_alu_src;
        alu_op_raw     = exe_alu_op;
        reg_write_raw  = 1'b1;
        mem_to_reg_raw = is_ld;
      end
      default: begin
      end
    endcase
  end

  // State registers; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      op_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Every output is forced low while reset is held, so a request or write
  // enable drops in the same cycle reset rises.
  assign bus.imem_req      = ~rst & imem_req_raw;
  assign bus.IRWrite       = ~rst & ir_write_raw;
  assign bus.PCWrite       = ~rst & ir_write_raw;
  assign bus.ALUSrc        = ~rst & alu_src_raw;
  assign bus.ALUOp         = rst ? 2'b00 : alu_op_raw;
  assign bus.MemRead       = ~rst & mem_read_raw;
  assign bus.MemWrite      = ~rst & mem_write_raw;
  assign bus.MemtoReg      = ~rst & mem_to_reg_raw;
  assign bus.RegWrite      = ~rst & reg_write_raw;
  assign bus.illegal_instr = ~rst & illegal_raw;
  assign bus.mem_fault     = ~rst & fault_raw;
  assign bus.state         = rst ? FETCH : state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm. A reference model plans whole instructions
// (opcode, ack delays, timeouts) into per-cycle stimulus and expected-output tables plus a
// queue of expected events; a monitor checks every cycle and pops an event whenever the DUT
// shows a pulse or a completed data handshake.
module tb_multicycle_control_fsm;

  localparam int TO          = 4;
  localparam int MAXC        = 4000;
  localparam int PLAN_TARGET = 2500;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  // Event kinds
  localparam int EV_FETCH = 1;
  localparam int EV_ILL   = 2;
  localparam int EV_FAULT = 3;
  localparam int EV_WB    = 4;
  localparam int EV_MACK  = 5;

  typedef struct {
    int   cyc;
    int   kind;
    logic m2r;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(
    .TIMEOUT (TO),
    .TO_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Planned stimulus and expected per-cycle outputs
  logic [6:0] p_opc  [MAXC];
  logic       p_iack [MAXC];
  logic       p_dack [MAXC];
  // {state[2:0], imem_req, MemRead, MemWrite, ALUSrc, ALUOp[1:0]}
  logic [8:0] x_exp  [MAXC];
  ev_t        exp_q[$];
  int         plan_len;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  function automatic logic [14:0] all_outs();
    return {bus.imem_req, bus.IRWrite, bus.PCWrite, bus.ALUSrc, bus.ALUOp, bus.MemRead,
            bus.MemWrite, bus.MemtoReg, bus.RegWrite, bus.illegal_instr, bus.mem_fault,
            bus.state};
  endfunction

  // {ALUSrc, ALUOp} per class: 0 R, 1 I, 2 LD, 3 ST
  function automatic logic [2:0] cls_ctl(input int cls);
    case (cls)
      0:       return 3'b0_10;
      1:       return 3'b1_00;
      default: return 3'b1_01;
    endcase
  endfunction

  // Expected {IRWrite, PCWrite, illegal_instr, mem_fault, RegWrite, MemtoReg} for an event
  function automatic logic [5:0] ev_vec(input int kind, input logic m2r);
    case (kind)
      EV_FETCH: return 6'b110000;
      EV_ILL:   return 6'b001000;
      EV_FAULT: return 6'b000100;
      EV_WB:    return {5'b00001, m2r};
      default:  return 6'b000000;
    endcase
  endfunction

  task automatic set_exp(input int c, input logic [2:0] st, input logic ireq, input logic rd,
                         input logic wr, input logic [2:0] ctl);
    x_exp[c] = {st, ireq, rd, wr, ctl};
  endtask

  task automatic push_ev(input int c, input int kind, input logic m2r);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.m2r  = m2r;
    exp_q.push_back(e);
  endtask

  // Ack delay: mostly within the window, sometimes past it (forced in after 3 faults)
  function automatic int pick_delay(input int faults);
    if (faults < 3 && $urandom_range(0, 4) == 0) return TO + int'($urandom_range(0, 1));
    return int'($urandom_range(0, TO - 1));
  endfunction

  // Plan one instruction starting with its first FETCH cycle at t; t returns the next start.
  task automatic plan_instr(inout int t);
    int         d;
    int         m;
    int         cls;
    int         faults;
    bit         done;
    logic [6:0] o;
    logic [2:0] ctl;
    faults = 0;
    done   = 1'b0;
    while (!done) begin
      d = pick_delay(faults);
      if (d < TO) begin
        for (int k = 0; k <= d; k++) begin
          set_exp(t + k, 3'd0, 1'b1, 1'b0, 1'b0, 3'b000);
          p_iack[t + k] = (k == d);
        end
        push_ev(t + d, EV_FETCH, 1'b0);
        t    = t + d + 1;
        done = 1'b1;
      end else begin
        for (int k = 0; k < TO; k++) begin
          set_exp(t + k, 3'd0, 1'b1, 1'b0, 1'b0, 3'b000);
          p_iack[t + k] = 1'b0;
        end
        push_ev(t + TO - 1, EV_FAULT, 1'b0);
        t      = t + TO;
        faults = faults + 1;
      end
    end
    cls = int'($urandom_range(0, 4));
    case (cls)
      0: o = OP_R;
      1: o = OP_I;
      2: o = OP_LD;
      3: o = OP_ST;
      default: begin
        do o = 7'($urandom);
        while (o == OP_R || o == OP_I || o == OP_LD || o == OP_ST);
      end
    endcase
    p_opc[t] = o;
    set_exp(t, 3'd1, 1'b0, 1'b0, 1'b0, 3'b000);
    if (cls == 4) begin
      push_ev(t, EV_ILL, 1'b0);
      t = t + 1;
      return;
    end
    ctl = cls_ctl(cls);
    set_exp(t + 1, 3'd2, 1'b0, 1'b0, 1'b0, ctl);
    if (cls < 2) begin
      set_exp(t + 2, 3'd4, 1'b0, 1'b0, 1'b0, ctl);
      push_ev(t + 2, EV_WB, 1'b0);
      t = t + 3;
      return;
    end
    m = t + 2;
    d = pick_delay(0);
    if (d < TO) begin
      for (int k = 0; k <= d; k++) begin
        set_exp(m + k, 3'd3, 1'b0, cls == 2, cls == 3, 3'b1_01);
        p_dack[m + k] = (k == d);
      end
      push_ev(m + d, EV_MACK, 1'b0);
      if (cls == 2) begin
        set_exp(m + d + 1, 3'd4, 1'b0, 1'b0, 1'b0, 3'b1_01);
        push_ev(m + d + 1, EV_WB, 1'b1);
        t = m + d + 2;
      end else begin
        t = m + d + 1;
      end
    end else begin
      for (int k = 0; k < TO; k++) begin
        set_exp(m + k, 3'd3, 1'b0, cls == 2, cls == 3, 3'b1_01);
        p_dack[m + k] = 1'b0;
      end
      push_ev(m + TO - 1, EV_FAULT, 1'b0);
      t = m + TO;
    end
  endtask

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: per-cycle Moore outputs, plus scoreboard pop on every observable event
  always @(negedge clk) begin
    if (chk_en && cyc < plan_len) begin
      logic [8:0] got_c;
      logic [5:0] got_e;
      ev_t        e;
      got_c = {bus.state, bus.imem_req, bus.MemRead, bus.MemWrite, bus.ALUSrc, bus.ALUOp};
      total = total + 1;
      if (got_c !== x_exp[cyc]) begin
        bad = bad + 1;
        $display("FAIL cycle_outputs cyc=%0d got=%b want=%b", cyc, got_c, x_exp[cyc]);
      end
      got_e = {bus.IRWrite, bus.PCWrite, bus.illegal_instr, bus.mem_fault, bus.RegWrite,
               bus.MemtoReg & bus.RegWrite};
      if ((|got_e) || ((bus.MemRead | bus.MemWrite) & bus.dmem_ack)) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, got_e);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || got_e !== ev_vec(e.kind, e.m2r)) begin
            bad = bad + 1;
            $display("FAIL event cyc=%0d got=%b want=%b at cyc=%0d (kind %0d)", cyc, got_e,
                     ev_vec(e.kind, e.m2r), e.cyc, e.kind);
          end
        end
      end
    end
  end

  initial begin
    int t;
    bus.Opcode   = OP_R;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;

    // Reset holds every output low even with acks asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 15'h0000);

    // Background noise: acks outside their requesting state must be ignored
    for (int c = 0; c < MAXC; c++) begin
      p_opc[c]  = 7'($urandom);
      p_iack[c] = 1'($urandom_range(0, 1));
      p_dack[c] = 1'($urandom_range(0, 1));
      x_exp[c]  = '0;
    end
    t = 0;
    while (t < PLAN_TARGET) plan_instr(t);
    plan_len = t;

    // Random phase: cycle 0 is the first cycle after reset falls
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cyc    = 0;
    chk_en = 1'b1;
    bus.Opcode   = p_opc[0];
    bus.imem_ack = p_iack[0];
    bus.dmem_ack = p_dack[0];
    for (int c = 1; c < plan_len; c++) begin
      @(posedge clk);
      #1;
      cyc          = c;
      bus.Opcode   = p_opc[c];
      bus.imem_ack = p_iack[c];
      bus.dmem_ack = p_dack[c];
    end
    @(posedge clk);
    #1;
    chk_en       = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL leftover_events got=%0d want=0", exp_q.size());
    end

    // Reset during the MEM state of a store
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.Opcode   = OP_ST;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.imem_ack = 1'b0;
    end
    @(negedge clk);
    check("store_in_mem", {12'h000, bus.MemWrite, bus.state[1:0]}, 15'h0007);
    #2;
    rst = 1'b1;
    #1;
    check("reset_midstore", all_outs(), 15'h0000);
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", all_outs(), 15'h0000);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    check("restart_fetch", all_outs(), 15'h4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
